// File: rtl/mul_div_unit_pkg.sv
// Shared instruction header: ALU op codes, multiply/divide op codes and FSM states.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } alu_op_e;

  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdDiv   = 3'd2,
    MdDivu  = 3'd3,
    MdMthi  = 3'd4,
    MdMtlo  = 3'd5,
    MdNop6  = 3'd6,
    MdNop7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} md_state_e;

  // Low 64 bits of the extended product are exact for both signed and unsigned operands.
  function automatic logic [63:0] mul_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
    logic [63:0] ae, be;
    ae = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    be = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ae * be;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider on magnitudes: one quotient bit per cycle, 32 cycles.
module div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] rem_q, quo_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        negq_q, negr_q, dvz_q, done_q;
  logic [31:0] a_abs, b_abs;

  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] sh, diff;
    sh   = {rem, quo[31]};
    diff = sh - {1'b0, dvs};
    if (!diff[32]) return {diff[31:0], quo[30:0], 1'b1};
    return {sh[31:0], quo[30:0], 1'b0};
  endfunction

  assign a_abs = (is_signed && dividend[31]) ? -dividend : dividend;
  assign b_abs = (is_signed && divisor[31]) ? -divisor : divisor;

  // The first quotient bit is resolved on the load edge, so 31 steps remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dvz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        {rem_q, quo_q} <= div_step(32'd0, a_abs, b_abs);
        dvs_q  <= b_abs;
        cnt_q  <= 5'd31;
        negq_q <= is_signed & (dividend[31] ^ divisor[31]);
        negr_q <= is_signed & dividend[31];
        dvz_q  <= (divisor == 32'd0);
      end else if (cnt_q != 5'd0) begin
        {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
        cnt_q  <= cnt_q - 5'd1;
        done_q <= (cnt_q == 5'd1);
      end
    end
  end

  // Divide by zero leaves remainder = |dividend|, which sign-fixes back to the dividend.
  assign quotient  = dvz_q ? 32'hFFFF_FFFF : (negq_q ? -quo_q : quo_q);
  assign remainder = negr_q ? -rem_q : rem_q;
  assign done      = done_q;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit with fixed-latency multiply and iterative divide.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_op_e      op;
  md_state_e   state_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [5:0]  cnt_q;
  logic [63:0] prod_q [MUL_CYCLES];
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem;

  assign op        = md_op_e'(mdop);
  assign div_start = (state_q == StIdle) && start && (op == MdDiv || op == MdDivu);

  div_iter u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .is_signed (op == MdDiv),
    .dividend  (SrcA),
    .divisor   (SrcB),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Free-running shift: the stage read at completion holds the product captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MUL_CYCLES; i++) prod_q[i] <= '0;
    end else begin
      prod_q[0] <= mul_product(SrcA, SrcB, op == MdMult);
      for (int unsigned i = 1; i < MUL_CYCLES; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            case (op)
              MdMult, MdMultu: begin
                state_q <= StMul;
                busy_q  <= 1'b1;
                cnt_q   <= 6'(MUL_CYCLES);
              end
              MdDiv, MdDivu: begin
                state_q <= StDiv;
                busy_q  <= 1'b1;
                cnt_q   <= 6'(DIV_CYCLES);
              end
              MdMthi:  hi_q <= SrcA;
              MdMtlo:  lo_q <= SrcA;
              default: ;
            endcase
          end
        end
        StMul: begin
          if (cnt_q == 6'd1) begin
            {hi_q, lo_q} <= prod_q[MUL_CYCLES-1];
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
          end else if (cnt_q != 6'd0) begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        StDiv: begin
          if (div_done) begin
            hi_q    <= div_rem;
            lo_q    <= div_quo;
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q != 6'd0) begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
